// File: rtl/branch_rs.sv
// branch_rs -- branch reservation station and issue scheduler.
//
// Buffers up to DEPTH dispatched branch micro-ops in age order (index 0 is
// the oldest), captures source operands from the CDB, and each cycle issues
// the oldest operand-ready entry into a comparator. The outcome is registered
// and offered to the ROB/branch-resolve logic over a valid/ready handshake.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               synchronous squash of all entries and the result
//   disp_*              dispatch request (valid/ready, cmpop, rob slot, sources)
//   cdb_*               common data bus broadcast (valid, tag, data)
//   res_*               branch outcome (valid/ready, rob slot, taken)

// Branch comparator; cmpop uses the rv32i funct3 encoding.
module cmp (
  input  logic [2:0]  cmpop,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        br_en
);
  always_comb begin
    br_en = 1'b0;
    case (cmpop)
      3'b000:  br_en = (a == b);
      3'b001:  br_en = (a != b);
      3'b100:  br_en = ($signed(a) <  $signed(b));
      3'b101:  br_en = ($signed(a) >= $signed(b));
      3'b110:  br_en = (a <  b);
      3'b111:  br_en = (a >= b);
      default: br_en = 1'b0;
    endcase
  end
endmodule

// Per-source wakeup: a not-ready source whose tag is broadcast becomes ready
// and takes the broadcast value. Used for stored entries and dispatch bypass.
module branch_rs_wake #(
  parameter int TAG_W = 6
) (
  input  logic             rdy,
  input  logic [TAG_W-1:0] tag,
  input  logic [31:0]      val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             rdy_n,
  output logic [31:0]      val_n
);
  logic hit;
  assign hit   = !rdy && cdb_valid && (tag == cdb_tag);
  assign rdy_n = rdy | hit;
  assign val_n = hit ? cdb_data : val;
endmodule

module branch_rs #(
  parameter int DEPTH = 4,
  parameter int ROB_W = 5,
  parameter int TAG_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             disp_valid,
  output logic             disp_ready,
  input  logic [2:0]       disp_cmpop,
  input  logic [ROB_W-1:0] disp_rob_idx,
  input  logic             disp_src1_rdy,
  input  logic [TAG_W-1:0] disp_src1_tag,
  input  logic [31:0]      disp_src1_val,
  input  logic             disp_src2_rdy,
  input  logic [TAG_W-1:0] disp_src2_tag,
  input  logic [31:0]      disp_src2_val,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic [31:0]      cdb_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ROB_W-1:0] res_rob_idx,
  output logic             res_br_en
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int SEL_W = $clog2(DEPTH);

  typedef struct packed {
    logic             vld;
    logic [2:0]       op;
    logic [ROB_W-1:0] rob;
    logic             r1;
    logic [TAG_W-1:0] t1;
    logic [31:0]      v1;
    logic             r2;
    logic [TAG_W-1:0] t2;
    logic [31:0]      v2;
  } ent_t;

  ent_t [DEPTH-1:0] ent_q, ent_d;
  // woke[DEPTH] is an always-empty slot so the top entry can collapse into it.
  ent_t [DEPTH:0]   woke;
  ent_t             disp_ent;

  logic [CNT_W-1:0] cnt_q, cnt_d, wr_idx;
  logic [SEL_W-1:0] sel_idx;
  logic             sel_found, issue, disp_fire, cmp_br_en;

  // Wakeup of stored entries at their current positions; the collapse below
  // then moves the woken copies, so wakeup lands on the collapsed positions.
  for (genvar g = 0; g < DEPTH; g++) begin : g_ent
    logic        r1_n, r2_n;
    logic [31:0] v1_n, v2_n;
    branch_rs_wake #(.TAG_W(TAG_W)) u_w1 (
      .rdy(ent_q[g].r1), .tag(ent_q[g].t1), .val(ent_q[g].v1),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rdy_n(r1_n), .val_n(v1_n));
    branch_rs_wake #(.TAG_W(TAG_W)) u_w2 (
      .rdy(ent_q[g].r2), .tag(ent_q[g].t2), .val(ent_q[g].v2),
      .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
      .rdy_n(r2_n), .val_n(v2_n));
    assign woke[g] = '{vld: ent_q[g].vld, op: ent_q[g].op, rob: ent_q[g].rob,
                       r1: r1_n, t1: ent_q[g].t1, v1: v1_n,
                       r2: r2_n, t2: ent_q[g].t2, v2: v2_n};
  end
  assign woke[DEPTH] = '0;

  // Dispatch bypass: a source broadcast in the dispatch cycle is captured.
  logic        d_r1, d_r2;
  logic [31:0] d_v1, d_v2;
  branch_rs_wake #(.TAG_W(TAG_W)) u_dw1 (
    .rdy(disp_src1_rdy), .tag(disp_src1_tag), .val(disp_src1_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rdy_n(d_r1), .val_n(d_v1));
  branch_rs_wake #(.TAG_W(TAG_W)) u_dw2 (
    .rdy(disp_src2_rdy), .tag(disp_src2_tag), .val(disp_src2_val),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .rdy_n(d_r2), .val_n(d_v2));
  assign disp_ent = '{vld: 1'b1, op: disp_cmpop, rob: disp_rob_idx,
                      r1: d_r1, t1: disp_src1_tag, v1: d_v1,
                      r2: d_r2, t2: disp_src2_tag, v2: d_v2};

  // No pass-through when full, even if an entry leaves this cycle.
  assign disp_ready = (cnt_q < CNT_W'(DEPTH));
  assign disp_fire  = disp_valid && disp_ready;

  // Oldest ready entry wins; select sees pre-wakeup state, so a CDB hit
  // becomes issuable on the following cycle.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_q[i].vld && ent_q[i].r1 && ent_q[i].r2) begin
        sel_found = 1'b1;
        sel_idx   = SEL_W'(i);
      end
    end
  end

  assign issue = sel_found && (!res_valid || res_ready);

  cmp u_cmp (
    .cmpop (ent_q[sel_idx].op),
    .a     (ent_q[sel_idx].v1),
    .b     (ent_q[sel_idx].v2),
    .br_en (cmp_br_en)
  );

  // Collapse above the issued slot, then append the dispatch at the tail.
  always_comb begin
    wr_idx = cnt_q - CNT_W'(issue);
    for (int i = 0; i < DEPTH; i++) begin
      ent_d[i] = (issue && (SEL_W'(i) >= sel_idx)) ? woke[i+1] : woke[i];
      if (disp_fire && (CNT_W'(i) == wr_idx)) ent_d[i] = disp_ent;
    end
  end

  assign cnt_d = cnt_q + CNT_W'(disp_fire) - CNT_W'(issue);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_q       <= '0;
      cnt_q       <= '0;
      res_valid   <= 1'b0;
      res_rob_idx <= '0;
      res_br_en   <= 1'b0;
    end else if (flush) begin
      ent_q     <= '0;
      cnt_q     <= '0;
      res_valid <= 1'b0;
    end else begin
      ent_q <= ent_d;
      cnt_q <= cnt_d;
      if (issue) begin
        res_valid   <= 1'b1;
        res_rob_idx <= ent_q[sel_idx].rob;
        res_br_en   <= cmp_br_en;
      end else if (res_ready) begin
        res_valid <= 1'b0;
      end
    end
  end
endmodule
